// File: rtl/mem_access_ctrl.sv
`timescale 1ns/1ps
// mem_access_ctrl
// ---------------
// MEM-stage data-memory sequencer. It decodes the load/store codes from the
// EXE/MEM register, issues one registered request on a req/ack memory port,
// and holds the pipeline stalled until the memory acknowledges or the wait
// limit runs out. Load results are lane-selected, extended and held in
// load_data for the MEM/WB register.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   DMRd[3:0]           load code (1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU, else none)
//   DMWr[1:0]           store code (1 SW, 2 SH, 3 SB, 0 none)
//   ALUout[31:0]        byte address of the access
//   DMdata[31:0]        store data
//   stall               combinational pipeline hold
//   misalign            combinational misaligned-access flag
//   mem_req/we/addr/be/wdata   registered memory request
//   mem_rdata, mem_ack  memory response
//   load_data[31:0]     registered, extended load result
//   bus_err             registered, high in DONE after a timeout
module mem_access_ctrl #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  DMRd,
   input  logic [1:0]  DMWr,
   input  logic [31:0] ALUout,
   input  logic [31:0] DMdata,
   output logic        stall,
   output logic        misalign,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic [31:0] load_data,
   output logic        bus_err
);

   localparam int CNT_W = $clog2(TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       rd_code_q, rd_code_d;
   logic [1:0]       lane_q, lane_d;
   logic             mem_req_q, mem_req_d;
   logic             mem_we_q, mem_we_d;
   logic [31:0]      mem_addr_q, mem_addr_d;
   logic [3:0]       mem_be_q, mem_be_d;
   logic [31:0]      mem_wdata_q, mem_wdata_d;
   logic [31:0]      load_data_q, load_data_d;
   logic             bus_err_q, bus_err_d;

   logic             is_load;
   logic             is_store;
   logic             access;
   logic             aligned;
   logic [3:0]       issue_be;
   logic [31:0]      issue_wdata;
   logic [15:0]      rd_half;
   logic [7:0]       rd_byte;
   logic [31:0]      ext_data;

   // Decode the incoming access. A load takes priority over a store when both
   // codes are present, so the store is only seen when no valid load exists.
   always_comb begin
      is_load     = (DMRd >= 4'd1) && (DMRd <= 4'd5);
      is_store    = !is_load && (DMWr != 2'd0);
      access      = is_load || is_store;
      aligned     = 1'b1;
      issue_be    = 4'b1111;
      issue_wdata = 32'd0;
      if (is_load) begin
         case (DMRd)
            4'd1:       aligned = (ALUout[1:0] == 2'b00);
            4'd2, 4'd3: aligned = !ALUout[0];
            default:    aligned = 1'b1;
         endcase
      end else if (is_store) begin
         case (DMWr)
            2'd1: begin
               aligned     = (ALUout[1:0] == 2'b00);
               issue_wdata = DMdata;
            end
            2'd2: begin
               aligned     = !ALUout[0];
               issue_be    = ALUout[1] ? 4'b1100 : 4'b0011;
               issue_wdata = {2{DMdata[15:0]}};
            end
            default: begin
               issue_be    = 4'b0001 << ALUout[1:0];
               issue_wdata = {4{DMdata[7:0]}};
            end
         endcase
      end
   end

   // Pick the addressed halfword/byte from the returned word using the lane
   // captured at issue, then extend according to the captured load code.
   always_comb begin
      rd_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (lane_q)
         2'd0:    rd_byte = mem_rdata[7:0];
         2'd1:    rd_byte = mem_rdata[15:8];
         2'd2:    rd_byte = mem_rdata[23:16];
         default: rd_byte = mem_rdata[31:24];
      endcase
      case (rd_code_q)
         4'd2:    ext_data = {{16{rd_half[15]}}, rd_half};
         4'd3:    ext_data = {16'd0, rd_half};
         4'd4:    ext_data = {{24{rd_byte[7]}}, rd_byte};
         4'd5:    ext_data = {24'd0, rd_byte};
         default: ext_data = mem_rdata;
      endcase
   end

   // Next-state and output logic. Everything holds by default; IDLE issues an
   // aligned access, BUSY waits for ack or the last count, DONE releases the
   // pipeline for one cycle and always returns to IDLE so an access still
   // sitting in EXE/MEM is not issued twice.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rd_code_d   = rd_code_q;
      lane_d      = lane_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      load_data_d = load_data_q;
      bus_err_d   = bus_err_q;
      stall       = 1'b0;
      misalign    = 1'b0;
      case (state_q)
         IDLE: begin
            if (access) begin
               if (aligned) begin
                  stall       = 1'b1;
                  state_d     = BUSY;
                  mem_req_d   = 1'b1;
                  mem_we_d    = is_store;
                  mem_addr_d  = {ALUout[31:2], 2'b00};
                  mem_be_d    = issue_be;
                  mem_wdata_d = issue_wdata;
                  rd_code_d   = is_load ? DMRd : 4'd0;
                  lane_d      = ALUout[1:0];
                  cnt_d       = '0;
               end else begin
                  misalign = 1'b1;
               end
            end
         end
         BUSY: begin
            stall = 1'b1;
            if (mem_ack) begin
               state_d   = DONE;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               bus_err_d = 1'b0;
               if (rd_code_q != 4'd0) begin
                  load_data_d = ext_data;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d     = DONE;
               mem_req_d   = 1'b0;
               mem_we_d    = 1'b0;
               load_data_d = 32'd0;
               bus_err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            state_d   = IDLE;
            bus_err_d = 1'b0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and request registers; reset drops an in-flight request at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rd_code_q   <= 4'd0;
         lane_q      <= 2'd0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_be_q    <= 4'd0;
         mem_wdata_q <= 32'd0;
         load_data_q <= 32'd0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rd_code_q   <= rd_code_d;
         lane_q      <= lane_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         load_data_q <= load_data_d;
         bus_err_q   <= bus_err_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_be    = mem_be_q;
   assign mem_wdata = mem_wdata_q;
   assign load_data = load_data_q;
   assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
`timescale 1ns/1ps
// tb_mem_access_ctrl
// ------------------
// Self-checking bench for mem_access_ctrl with TIMEOUT=4. A transaction-level
// reference model tracks what the memory port and load result must be; a
// compare process checks every output on each falling edge. Directed scenarios
// pin the model with hand-computed values, then randomized traffic follows.
module tb_mem_access_ctrl;

   localparam int TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  DMRd;
   logic [1:0]  DMWr;
   logic [31:0] ALUout;
   logic [31:0] DMdata;
   logic        stall;
   logic        misalign;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic [31:0] load_data;
   logic        bus_err;

   int nChecks = 0;
   int nErrors = 0;
   logic checkEn = 1'b0;

   mem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .DMRd      (DMRd),
      .DMWr      (DMWr),
      .ALUout    (ALUout),
      .DMdata    (DMdata),
      .stall     (stall),
      .misalign  (misalign),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_be    (mem_be),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .load_data (load_data),
      .bus_err   (bus_err)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Model helpers: access size in bytes (0 = no access), load detection,
   // byte enables, replicated store data and load extension by arithmetic.
   function automatic int accSize(input logic [3:0] rd, input logic [1:0] wr);
      if (rd == 4'd1) return 4;
      if (rd == 4'd2 || rd == 4'd3) return 2;
      if (rd == 4'd4 || rd == 4'd5) return 1;
      if (wr == 2'd1) return 4;
      if (wr == 2'd2) return 2;
      if (wr == 2'd3) return 1;
      return 0;
   endfunction

   function automatic bit isLoadF(input logic [3:0] rd);
      return (rd >= 4'd1 && rd <= 4'd5);
   endfunction

   function automatic bit misF(input int size, input logic [31:0] addr);
      int low;
      low = int'(addr[1:0]);
      return (size != 0) && ((low % size) != 0);
   endfunction

   function automatic logic [3:0] beF(input int size, input logic [31:0] addr);
      int mask;
      mask = ((1 << size) - 1) << int'(addr[1:0]);
      return 4'(mask);
   endfunction

   function automatic logic [31:0] wdataF(input int size, input logic [31:0] d);
      if (size == 2) return (d & 32'h0000_FFFF) * 32'h0001_0001;
      if (size == 1) return (d & 32'h0000_00FF) * 32'h0101_0101;
      return d;
   endfunction

   function automatic logic [31:0] extF(input int rd, input int lane, input logic [31:0] rdata);
      logic [31:0] sh;
      logic [31:0] v;
      sh = rdata >> (8 * lane);
      case (rd)
         2: begin v = sh & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF_0000; end
         3: v = sh & 32'hFFFF;
         4: begin v = sh & 32'hFF; if (v >= 32'h80) v = v | 32'hFFFF_FF00; end
         5: v = sh & 32'hFF;
         default: v = rdata;
      endcase
      return v;
   endfunction

   // Reference model state: phase 0 waiting, 1 request outstanding, 2 one
   // cycle of completion. mWait counts outstanding cycles already spent.
   int          mPh;
   logic        mReq, mWe, mWeKnown, mErr;
   logic [31:0] mAddr, mWdata, mLd;
   logic [3:0]  mBe;
   int          mRd, mLane, mWait;

   // Reference model update on each rising edge (and immediately on reset).
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mPh <= 0; mReq <= 1'b0; mWe <= 1'b0; mWeKnown <= 1'b1; mErr <= 1'b0;
         mAddr <= 32'd0; mWdata <= 32'd0; mLd <= 32'd0; mBe <= 4'd0;
         mRd <= 0; mLane <= 0; mWait <= 0;
      end else begin
         case (mPh)
            0: begin
               if (accSize(DMRd, DMWr) != 0 && !misF(accSize(DMRd, DMWr), ALUout)) begin
                  mPh      <= 1;
                  mReq     <= 1'b1;
                  mWe      <= !isLoadF(DMRd);
                  mWeKnown <= 1'b1;
                  mAddr    <= ALUout & ~32'd3;
                  mBe      <= isLoadF(DMRd) ? 4'hF : beF(accSize(DMRd, DMWr), ALUout);
                  mWdata   <= wdataF(accSize(DMRd, DMWr), DMdata);
                  mRd      <= isLoadF(DMRd) ? int'(DMRd) : 0;
                  mLane    <= int'(ALUout[1:0]);
                  mWait    <= 0;
               end
            end
            1: begin
               if (mem_ack) begin
                  mPh  <= 2; mReq <= 1'b0; mWe <= 1'b0; mErr <= 1'b0;
                  if (mRd != 0) mLd <= extF(mRd, mLane, mem_rdata);
               end else if (mWait == TIMEOUT - 1) begin
                  mPh <= 2; mReq <= 1'b0; mWeKnown <= 1'b0; mLd <= 32'd0; mErr <= 1'b1;
               end else begin
                  mWait <= mWait + 1;
               end
            end
            default: begin
               mPh  <= 0;
               mErr <= 1'b0;
            end
         endcase
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every DUT output against the model for the current cycle.
   task automatic checkOutput();
      int  size;
      bit  mis;
      size = accSize(DMRd, DMWr);
      mis  = misF(size, ALUout);
      chk("stall", 32'(stall), 32'((mPh == 1) || (mPh == 0 && size != 0 && !mis)));
      chk("misalign", 32'(misalign), 32'(mPh == 0 && size != 0 && mis));
      chk("mem_req", 32'(mem_req), 32'(mReq));
      if (mWeKnown) chk("mem_we", 32'(mem_we), 32'(mWe));
      chk("mem_addr", mem_addr, mAddr);
      chk("mem_be", 32'(mem_be), 32'(mBe));
      if (mReq && mWe) chk("mem_wdata", mem_wdata, mWdata);
      chk("load_data", load_data, mLd);
      chk("bus_err", 32'(bus_err), 32'(mErr));
   endtask

   // One compare process, sampling on the falling edge.
   always @(negedge clk) begin
      if (checkEn) checkOutput();
   end

   task automatic applyStimulus(input logic [3:0] rd, input logic [1:0] wr,
                                input logic [31:0] addr, input logic [31:0] data,
                                input logic [31:0] rdata, input logic ack);
      @(posedge clk);
      #2;
      DMRd = rd; DMWr = wr; ALUout = addr; DMdata = data;
      mem_rdata = rdata; mem_ack = ack;
   endtask

   // Present one access, hold it, and ack on BUSY cycle index ackDelay (a
   // delay >= TIMEOUT never acks). Returns stall/request cycle counts, the
   // request seen in the first BUSY cycle and the DONE-cycle result.
   task automatic doAccess(input logic [3:0] rd, input logic [1:0] wr,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] rdata, input int ackDelay,
                           output int stallCnt, output int reqCnt,
                           output logic [31:0] ld, output logic err,
                           output logic we, output logic [3:0] be,
                           output logic [31:0] maddr, output logic [31:0] wdata);
      bit done;
      stallCnt = 0; reqCnt = 0; done = 0;
      ld = 32'd0; err = 1'b0; we = 1'b0; be = 4'd0; maddr = 32'd0; wdata = 32'd0;
      applyStimulus(rd, wr, addr, data, rdata, 1'b0);
      for (int j = 0; j < TIMEOUT + 4 && !done; j++) begin
         if (j > 0) applyStimulus(rd, wr, addr, data, rdata, (j - 1) == ackDelay);
         @(negedge clk);
         #1;
         if (stall) stallCnt++;
         if (mem_req) reqCnt++;
         if (j == 1) begin we = mem_we; be = mem_be; maddr = mem_addr; wdata = mem_wdata; end
         if (j > 0 && !stall) begin done = 1; ld = load_data; err = bus_err; end
      end
      if (!done) begin
         nChecks++;
         nErrors++;
         $display("[TB] FAIL access completion: stall never dropped within %0d cycles", TIMEOUT + 4);
      end
   endtask

   int          sc, rc;
   logic [31:0] ld, ma, wd;
   logic        er, we;
   logic [3:0]  be;

   // Directed scenarios with literal expectations, then randomized traffic.
   initial begin
      rst = 1'b1; DMRd = 4'd0; DMWr = 2'd0; ALUout = 32'd0; DMdata = 32'd0;
      mem_rdata = 32'd0; mem_ack = 1'b0;
      #12;
      chk("reset mem_req", 32'(mem_req), 32'd0);
      chk("reset load_data", load_data, 32'd0);
      chk("reset stall", 32'(stall), 32'd0);
      @(posedge clk); #2; rst = 1'b0;
      checkEn = 1'b1;

      doAccess(4'd4, 2'd0, 32'h1003, 32'd0, 32'h80FF_1234, 0, sc, rc, ld, er, we, be, ma, wd);
      chk("LB stall cycles", 32'(sc), 32'd2);
      chk("LB mem_addr", ma, 32'h1000);
      chk("LB mem_be", 32'(be), 32'hF);
      chk("LB load_data", ld, 32'hFFFF_FF80);
      applyStimulus(4'd0, 2'd0, 32'd0, 32'd0, 32'd0, 1'b0);

      doAccess(4'd5, 2'd0, 32'h1003, 32'd0, 32'h80FF_1234, 0, sc, rc, ld, er, we, be, ma, wd);
      chk("LBU load_data", ld, 32'h0000_0080);
      applyStimulus(4'd0, 2'd0, 32'd0, 32'd0, 32'd0, 1'b0);

      doAccess(4'd0, 2'd2, 32'h2002, 32'hDEAD_BEEF, 32'h5555_AAAA, 0, sc, rc, ld, er, we, be, ma, wd);
      chk("SH mem_we", 32'(we), 32'd1);
      chk("SH mem_be", 32'(be), 32'hC);
      chk("SH mem_wdata", wd, 32'hBEEF_BEEF);
      chk("SH load_data kept", ld, 32'h0000_0080);
      applyStimulus(4'd0, 2'd0, 32'd0, 32'd0, 32'd0, 1'b0);

      applyStimulus(4'd1, 2'd0, 32'h0005, 32'd0, 32'd0, 1'b0);
      @(negedge clk); #1;
      chk("misaligned LW flag", 32'(misalign), 32'd1);
      chk("misaligned LW stall", 32'(stall), 32'd0);
      applyStimulus(4'd0, 2'd0, 32'd0, 32'd0, 32'd0, 1'b0);
      @(negedge clk); #1;
      chk("misaligned LW no request", 32'(mem_req), 32'd0);

      doAccess(4'd1, 2'd0, 32'h0010, 32'd0, 32'h1234_5678, 99, sc, rc, ld, er, we, be, ma, wd);
      chk("timeout req cycles", 32'(rc), 32'd4);
      chk("timeout stall cycles", 32'(sc), 32'd5);
      chk("timeout bus_err", 32'(er), 32'd1);
      chk("timeout load_data", ld, 32'd0);
      applyStimulus(4'd0, 2'd0, 32'd0, 32'd0, 32'd0, 1'b0);

      doAccess(4'd1, 2'd0, 32'h0010, 32'd0, 32'hCAFE_F00D, 3, sc, rc, ld, er, we, be, ma, wd);
      chk("late ack stall cycles", 32'(sc), 32'd5);
      chk("late ack bus_err", 32'(er), 32'd0);
      chk("late ack load_data", ld, 32'hCAFE_F00D);

      doAccess(4'd1, 2'd0, 32'h0000, 32'd0, 32'h1111_2222, 1, sc, rc, ld, er, we, be, ma, wd);
      chk("b2b LW stall cycles", 32'(sc), 32'd3);
      chk("b2b LW load_data", ld, 32'h1111_2222);
      doAccess(4'd2, 2'd0, 32'h0002, 32'd0, 32'h8001_0000, 1, sc, rc, ld, er, we, be, ma, wd);
      chk("b2b LH stall cycles", 32'(sc), 32'd3);
      chk("b2b LH req cycles", 32'(rc), 32'd2);
      chk("b2b LH load_data", ld, 32'hFFFF_8001);
      applyStimulus(4'd0, 2'd0, 32'd0, 32'd0, 32'd0, 1'b0);

      applyStimulus(4'd1, 2'd0, 32'h0040, 32'd0, 32'd0, 1'b0);
      applyStimulus(4'd0, 2'd0, 32'd0, 32'd0, 32'd0, 1'b0);
      rst = 1'b1;
      #1;
      chk("mid-busy reset mem_req", 32'(mem_req), 32'd0);
      chk("mid-busy reset mem_be", 32'(mem_be), 32'd0);
      chk("mid-busy reset load_data", load_data, 32'd0);
      chk("mid-busy reset bus_err", 32'(bus_err), 32'd0);
      @(posedge clk); #2; rst = 1'b0;
      @(negedge clk); #1;
      chk("abandoned request not resumed", 32'(mem_req), 32'd0);
      doAccess(4'd0, 2'd3, 32'h3001, 32'h0000_00AB, 32'd0, 0, sc, rc, ld, er, we, be, ma, wd);
      chk("SB after reset mem_be", 32'(be), 32'h2);
      chk("SB after reset mem_wdata", wd, 32'hABAB_ABAB);
      chk("SB after reset stall cycles", 32'(sc), 32'd2);

      for (int i = 0; i < 2500; i++) begin
         applyStimulus(4'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                       {$urandom} , $urandom, $urandom, $urandom_range(0, 3) == 0);
         rst = ($urandom_range(0, 299) == 0);
      end
      applyStimulus(4'd0, 2'd0, 32'd0, 32'd0, 32'd0, 1'b0);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); #2;
      checkEn = 1'b0;
      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule
